icache_ctrl: RTL and testbench

// - Direct-mapped, read-only instruction cache between the F stage and instruction memory.
// - F stage presents the PC every cycle. On a hit, the instruction is returned in the same cycle.
// - On a miss: asserts icache_stall, refills the whole line from memory over a req/gnt + beat

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_array.sv | 47 ++++
 rtl/icache_ctrl.sv | 114 +++++++++++
 tb/tb_icache_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared geometry, FSM encoding and constants for the instruction cache.
package icache_pkg;
    localparam int LINES      = 16;
    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 32;

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DONE
    } state_e;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    endfunction
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, one word write port plus tag/valid set.
// Only the valid bits are reset; invalidate-all has priority over a tag write.
module icache_array
    import icache_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_word_en_i,
    input  logic             wr_tag_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [31:0]      wr_data_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             inv_all_i
);
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES*LINE_WORDS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (wr_tag_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_tag_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (wr_word_en_i) begin
            data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache: same-cycle hit, miss refills a full line via req/gnt + beats.
// Stall stays high from the miss cycle through the DONE bubble; memory beats outside FILL are dropped.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              inv_i,
    output logic [31:0]       instr_o,
    output logic              icache_stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_e            state_q;
    logic [OFF_W-1:0]  cnt_q;
    logic              inv_pend_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] miss_addr_q;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             pc_unused;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;
    logic             hit;
    logic             beat;
    logic             last_beat;
    logic             inv_all;

    assign pc_off    = pc_i[2 +: OFF_W];
    assign pc_idx    = pc_i[OFF_W+2 +: IDX_W];
    assign pc_tag    = pc_i[ADDR_W-1 -: TAG_W];
    assign pc_unused = ^pc_i[1:0];

    assign lookup_hit = rd_valid && (rd_tag == pc_tag);
    assign hit        = lookup_hit && (state_q == ST_IDLE);

    assign instr_o        = hit ? rd_data : NOP;
    assign icache_stall_o = !hit;
    assign mem_req_o      = mem_req_q;
    assign mem_addr_o     = miss_addr_q;

    assign beat      = (state_q == ST_FILL) && mem_rvalid_i;
    assign last_beat = beat && (cnt_q == LAST_BEAT);
    // An invalidate seen during a refill is deferred so the line being filled is cleared too.
    assign inv_all   = ((state_q == ST_IDLE) && inv_i) ||
                       ((state_q == ST_DONE) && (inv_i || inv_pend_q));

    icache_array u_array (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rd_idx_i     (pc_idx),
        .rd_off_i     (pc_off),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_word_en_i (beat),
        .wr_tag_en_i  (last_beat),
        .wr_idx_i     (miss_addr_q[OFF_W+2 +: IDX_W]),
        .wr_off_i     (cnt_q),
        .wr_data_i    (mem_rdata_i),
        .wr_tag_i     (miss_addr_q[ADDR_W-1 -: TAG_W]),
        .inv_all_i    (inv_all)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            inv_pend_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!lookup_hit) begin
                        miss_addr_q <= line_base(pc_i);
                        mem_req_q   <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (inv_i) inv_pend_q <= 1'b1;
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (inv_i) inv_pend_q <= 1'b1;
                    if (mem_rvalid_i) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (cnt_q == LAST_BEAT) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    inv_pend_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed table-driven bench for icache_ctrl plus hand sequences for inv and reset mid-refill.
module tb_icache_ctrl;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        inv, gnt, rv;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic        stall, req;
    logic [31:0] addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pc_i           (pc),
        .inv_i          (inv),
        .instr_o        (instr),
        .icache_stall_o (stall),
        .mem_req_o      (req),
        .mem_addr_o     (addr),
        .mem_gnt_i      (gnt),
        .mem_rvalid_i   (rv),
        .mem_rdata_i    (rdata)
    );

    typedef struct {
        logic [31:0] pc;
        logic        inv, gnt, rv;
        logic [31:0] rdata;
        logic        stall;
        logic [31:0] instr;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] p, input logic i, input logic g, input logic r,
                       input logic [31:0] d, input logic s, input logic [31:0] ins,
                       input logic q, input logic [31:0] a);
        vec_t v;
        v.pc = p; v.inv = i; v.gnt = g; v.rv = r; v.rdata = d;
        v.stall = s; v.instr = ins; v.req = q; v.addr = a;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Miss on pc=a from IDLE, optional gnt delay and inv on one beat; ends back in IDLE.
    task automatic do_refill(input logic [31:0] a, input logic [31:0] d0,
                             input int inv_beat, input int gnt_wait);
        pc = a; inv = 0; gnt = 0; rv = 0;
        #2;
        chk("refill miss stall", {31'd0, stall}, 32'd1);
        chk("refill miss req", {31'd0, req}, 32'd0);
        step();
        for (int w = 0; w < gnt_wait; w++) begin
            #2 chk("refill wait req", {31'd0, req}, 32'd1);
            step();
        end
        gnt = 1;
        #2;
        chk("refill req", {31'd0, req}, 32'd1);
        chk("refill addr", addr, a & 32'hFFFF_FFF0);
        step();
        gnt = 0;
        for (int b = 0; b < 4; b++) begin
            rv = 1; rdata = d0 + b; inv = (b == inv_beat);
            #2 chk("refill beat stall", {31'd0, stall}, 32'd1);
            step();
        end
        rv = 0; inv = 0;
        #2 chk("refill done stall", {31'd0, stall}, 32'd1);
        step();
    endtask

    initial begin
        rst_n = 0; pc = 32'h100; inv = 0; gnt = 0; rv = 0; rdata = 0;

        // pc, inv, gnt, rv, rdata, stall, instr, req, addr
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 1, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 0, 1, 'hA0, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 1, 'hA1, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 1, 'hA2, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 1, 'hA3, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    0, 'hA0, 0, 0);
        add(32'h104, 0, 0, 0, 0,    0, 'hA1, 0, 0);
        add(32'h108, 0, 0, 0, 0,    0, 'hA2, 0, 0);
        add(32'h10C, 0, 0, 0, 0,    0, 'hA3, 0, 0);
        add(32'h200, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h200, 0, 1, 0, 0,    1, NOPI, 1, 32'h200);
        add(32'h200, 0, 0, 1, 'hB0, 1, NOPI, 0, 0);
        add(32'h200, 0, 0, 1, 'hB1, 1, NOPI, 0, 0);
        add(32'h200, 0, 0, 1, 'hB2, 1, NOPI, 0, 0);
        add(32'h200, 0, 0, 1, 'hB3, 1, NOPI, 0, 0);
        add(32'h200, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h200, 0, 0, 0, 0,    0, 'hB0, 0, 0);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 0, 1, 'hDEAD_BEEF, 1, NOPI, 1, 32'h100);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 1, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h100, 0, 0, 1, 'hC0, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h100, 0, 0, 1, 'hC1, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h100, 0, 0, 1, 'hC2, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h100, 0, 0, 1, 'hC3, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 1, 'hBAD, 1, NOPI, 0, 0);
        add(32'h100, 0, 0, 0, 0,    0, 'hC0, 0, 0);
        add(32'h108, 0, 0, 0, 0,    0, 'hC2, 0, 0);
        add(32'h10C, 1, 0, 0, 0,    0, 'hC3, 0, 0);
        add(32'h10C, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h10C, 0, 1, 0, 0,    1, NOPI, 1, 32'h100);
        add(32'h10C, 0, 0, 1, 'h550, 1, NOPI, 0, 0);
        add(32'h10C, 0, 0, 1, 'h551, 1, NOPI, 0, 0);
        add(32'h10C, 0, 0, 1, 'h552, 1, NOPI, 0, 0);
        add(32'h10C, 0, 0, 1, 'h553, 1, NOPI, 0, 0);
        add(32'h10C, 0, 0, 0, 0,    1, NOPI, 0, 0);
        add(32'h10C, 0, 0, 0, 0,    0, 'h553, 0, 0);

        step();
        #1;
        chk("reset stall", {31'd0, stall}, 32'd1);
        chk("reset req", {31'd0, req}, 32'd0);
        chk("reset addr", addr, 32'd0);
        chk("reset instr", instr, NOPI);
        step();
        rst_n = 1;

        foreach (vecs[i]) begin
            pc = vecs[i].pc; inv = vecs[i].inv; gnt = vecs[i].gnt;
            rv = vecs[i].rv; rdata = vecs[i].rdata;
            #2;
            chk($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].stall});
            chk($sformatf("vec%0d instr", i), instr, vecs[i].instr);
            chk($sformatf("vec%0d req", i), {31'd0, req}, {31'd0, vecs[i].req});
            if (vecs[i].req) chk($sformatf("vec%0d addr", i), addr, vecs[i].addr);
            step();
        end
        inv = 0; gnt = 0; rv = 0;

        // inv on beat 2: fill completes but the line is gone afterwards
        do_refill(32'h300, 32'hD0, 2, 0);
        pc = 32'h300;
        #2 chk("inv mid-fill remiss", {31'd0, stall}, 32'd1);
        do_refill(32'h300, 32'hE0, -1, 0);
        pc = 32'h300;
        #2 chk("refill after inv instr", instr, 32'hE0);
        chk("refill after inv stall", {31'd0, stall}, 32'd0);
        step();
        pc = 32'h30C;
        #2 chk("refill after inv word3", instr, 32'hE3);
        step();

        // reset after beat 1 of a refill
        pc = 32'h400; step();
        gnt = 1; step(); gnt = 0;
        rv = 1; rdata = 32'hF0; step();
        rdata = 32'hF1; step();
        rst_n = 0;
        #1;
        chk("mid-reset req", {31'd0, req}, 32'd0);
        chk("mid-reset stall", {31'd0, stall}, 32'd1);
        chk("mid-reset addr", addr, 32'd0);
        rdata = 32'hF2; step();
        rdata = 32'hF3; step();
        rst_n = 1; rv = 0;
        do_refill(32'h400, 32'h60, -1, 1);
        pc = 32'h400;
        #2 chk("post-reset instr0", instr, 32'h60);
        step();
        pc = 32'h404;
        #2 chk("post-reset instr1", instr, 32'h61);
        pc = 32'h300;
        #1 chk("post-reset old line", {31'd0, stall}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
